// File: rtl/apu_pkg.sv
// Shared types and sizes for the APU audio frame sequencers.
package apu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        SCALE,
        LOAD
    } state_t;

    localparam int NUM_CH   = 4;
    localparam int SAMPLE_W = 4;
    // Four 4-bit samples sum to at most 60.
    localparam int MIX_W    = 6;
    // 60 * 8 = 480 fits in 9 bits, so the volume multiply never saturates.
    localparam int PROD_W   = 9;

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running frame divider: counts 0..DIV-1 and flags the last count.
module sample_tick_gen #(
    parameter int DIV = 2048
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] r_count;
    logic             w_last;

    assign w_last = (r_count == CNT_W'(DIV - 1));
    assign tick   = w_last;

    // Wrap explicitly so non-power-of-two dividers keep an exact period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/apu_pwm_scheduler.sv
// Once per sample frame, polls the four APU channels in round-robin slots,
// mixes the held samples, applies master volume and updates the DAC word.
module apu_pwm_scheduler
    import apu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIV   = 2048
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CH-1:0]             ch_valid,
    input  logic [NUM_CH*SAMPLE_W-1:0]    ch_data,
    output logic [NUM_CH-1:0]             ch_ready,
    input  logic [NUM_CH-1:0]             ch_enable,
    input  logic [2:0]                    master_vol,
    input  logic                          underrun_clr,
    output logic [WIDTH-1:0]              dac_out,
    output logic                          sample_strobe,
    output logic [NUM_CH-1:0]             underrun
);

    state_t              r_state;
    logic [1:0]          r_slot;
    logic [SAMPLE_W-1:0] r_held [NUM_CH];
    logic [PROD_W-1:0]   r_prod;
    logic [NUM_CH-1:0]   r_ch_ready;
    logic [NUM_CH-1:0]   r_underrun;
    logic [WIDTH-1:0]    r_dac;
    logic                r_strobe;

    logic                w_tick;
    logic [SAMPLE_W-1:0] w_slot_data;
    logic [MIX_W-1:0]    w_mix;
    logic [3:0]          w_gain;
    logic [PROD_W-1:0]   w_prod;
    logic [NUM_CH-1:0]   w_und_set;

    sample_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick)
    );

    assign w_slot_data = ch_data[r_slot*SAMPLE_W +: SAMPLE_W];
    assign w_gain      = {1'b0, master_vol} + 4'd1;
    assign w_prod      = PROD_W'(w_mix) * PROD_W'(w_gain);

    // Mixer: plain sum of the four held samples.
    always_comb begin
        w_mix = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_mix = w_mix + MIX_W'(r_held[i]);
        end
    end

    // An enabled channel that has nothing to offer in its own slot flags an underrun.
    always_comb begin
        w_und_set = '0;
        if (r_state == COLLECT && ch_enable[r_slot] && !ch_valid[r_slot]) begin
            w_und_set[r_slot] = 1'b1;
        end
    end

    // Frame sequencer: IDLE -> 4 COLLECT slots -> SCALE -> LOAD -> IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_slot     <= '0;
            r_prod     <= '0;
            r_ch_ready <= '0;
            r_dac      <= '0;
            r_strobe   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_held[i] <= '0;
            end
        end else begin
            r_strobe <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_tick) begin
                        r_state    <= COLLECT;
                        r_slot     <= '0;
                        r_ch_ready <= NUM_CH'(1);
                    end
                end
                COLLECT: begin
                    // Disabled channels still get their grant, but offered data is dropped.
                    if (ch_enable[r_slot]) begin
                        if (ch_valid[r_slot]) begin
                            r_held[r_slot] <= w_slot_data;
                        end
                    end else begin
                        r_held[r_slot] <= '0;
                    end
                    if (r_slot == 2'd3) begin
                        r_state    <= SCALE;
                        r_ch_ready <= '0;
                    end else begin
                        r_slot     <= r_slot + 2'd1;
                        r_ch_ready <= {r_ch_ready[NUM_CH-2:0], 1'b0};
                    end
                end
                SCALE: begin
                    // master_vol only matters in this cycle.
                    r_prod  <= w_prod;
                    r_state <= LOAD;
                end
                LOAD: begin
                    r_dac    <= WIDTH'(r_prod) << (WIDTH - PROD_W);
                    r_strobe <= 1'b1;
                    r_state  <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Sticky underrun flags; a clear wins over a set in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_underrun <= '0;
        end else if (underrun_clr) begin
            r_underrun <= '0;
        end else begin
            r_underrun <= r_underrun | w_und_set;
        end
    end

    assign ch_ready      = r_ch_ready;
    assign dac_out       = r_dac;
    assign sample_strobe = r_strobe;
    assign underrun      = r_underrun;

endmodule

// File: tb/tb_apu_pwm_scheduler.sv
// Randomised scoreboard bench for apu_pwm_scheduler with a frame-level model.
module tb_apu_pwm_scheduler;

    localparam int WIDTH = 16;
    localparam int DIV   = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [3:0]        ch_valid;
    logic [15:0]       ch_data;
    logic [3:0]        ch_ready;
    logic [3:0]        ch_enable;
    logic [2:0]        master_vol;
    logic              underrun_clr;
    logic [WIDTH-1:0]  dac_out;
    logic              sample_strobe;
    logic [3:0]        underrun;

    apu_pwm_scheduler #(
        .WIDTH (WIDTH),
        .DIV   (DIV)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ch_valid      (ch_valid),
        .ch_data       (ch_data),
        .ch_ready      (ch_ready),
        .ch_enable     (ch_enable),
        .master_vol    (master_vol),
        .underrun_clr  (underrun_clr),
        .dac_out       (dac_out),
        .sample_strobe (sample_strobe),
        .underrun      (underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [15:0] val;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    bit          active   = 1'b0;
    int          m_held[4];
    logic [3:0]  m_und        = '0;
    logic [3:0]  exp_und_cur  = '0;
    logic [15:0] last_dac     = '0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle stimulus: random by default, directed frames for the named scenarios.
    task automatic drive(int phase, int f, int pos);
        for (int i = 0; i < 4; i++) begin
            ch_valid[i]  = ($urandom_range(0, 7) != 0);
            ch_enable[i] = ($urandom_range(0, 7) != 0);
        end
        ch_data      = 16'($urandom);
        master_vol   = 3'($urandom);
        underrun_clr = ($urandom_range(0, 15) == 0);
        if (phase == 0 && f >= 1 && f <= 6) begin
            ch_valid     = 4'hF;
            ch_enable    = 4'hF;
            ch_data      = 16'h4321;
            master_vol   = 3'd0;
            underrun_clr = 1'b0;
            case (f)
                1: begin ch_data = 16'hFFFF; master_vol = 3'd7; end
                3: ch_enable = 4'b1011;
                4: begin ch_valid = 4'b1101; ch_data = 16'h1234; end
                5: underrun_clr = (pos == DIV - 1);
                6: master_vol = (pos == 0) ? 3'd0 : 3'd7;
                default: ;
            endcase
        end
        if (phase == 1 && f == 1) begin
            ch_valid     = 4'h0;
            ch_enable    = 4'hF;
            underrun_clr = 1'b0;
        end
    endtask

    // Frame-level reference: slot i of a frame is cycle position i; mix at position 4,
    // new DAC word two cycles later.
    task automatic model_step();
        int         pos;
        int         mix;
        int         prod;
        logic [3:0] set;
        exp_t       e;
        exp_und_cur = m_und;
        set = '0;
        pos = cyc % DIV;
        if (cyc >= DIV) begin
            if (pos < 4) begin
                if (ch_enable[pos]) begin
                    if (ch_valid[pos]) m_held[pos] = int'(ch_data[4*pos +: 4]);
                    else               set[pos] = 1'b1;
                end else begin
                    m_held[pos] = 0;
                end
            end
            if (pos == 4) begin
                mix   = m_held[0] + m_held[1] + m_held[2] + m_held[3];
                prod  = mix * (int'(master_vol) + 1);
                e.cyc = cyc + 2;
                e.val = 16'(prod << (WIDTH - 9));
                sb_q.push_back(e);
            end
        end
        m_und = underrun_clr ? 4'h0 : (m_und | set);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_held[i] = 0;
        m_und       = '0;
        exp_und_cur = '0;
        last_dac    = '0;
        sb_q.delete();
    endtask

    // Monitor: compares DUT outputs each cycle, popping the scoreboard on strobes.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (active) begin
                logic [3:0] exp_rdy;
                bit         exp_stb;
                int         pos;
                pos     = cyc % DIV;
                exp_rdy = (cyc >= DIV && pos < 4) ? 4'(1 << pos) : 4'h0;
                check("ch_ready", 32'(ch_ready), 32'(exp_rdy));
                check("underrun", 32'(underrun), 32'(exp_und_cur));
                while (sb_q.size() > 0 && sb_q[0].cyc < cyc) void'(sb_q.pop_front());
                exp_stb = (sb_q.size() > 0 && sb_q[0].cyc == cyc);
                check("sample_strobe", 32'(sample_strobe), 32'(exp_stb));
                if (exp_stb) begin
                    check("dac_out", 32'(dac_out), 32'(sb_q[0].val));
                    last_dac = sb_q[0].val;
                    void'(sb_q.pop_front());
                end else begin
                    check("dac_hold", 32'(dac_out), 32'(last_dac));
                end
            end
        end
    end

    // Driver: reset, directed + random frames, mid-frame reset, random frames.
    initial begin
        reset        = 1'b1;
        ch_valid     = '0;
        ch_data      = '0;
        ch_enable    = '0;
        master_vol   = '0;
        underrun_clr = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);

        reset  = 1'b0;
        active = 1'b1;
        for (int n = 0; n < 21 * DIV + 2; n++) begin
            if (n > 0) @(negedge clk);
            cyc = n;
            drive(0, n / DIV, n % DIV);
            model_step();
        end

        // Reset lands in slot 2 of frame 21.
        @(negedge clk);
        active = 1'b0;
        reset  = 1'b1;
        #1;
        check("rst_dac_out", 32'(dac_out), 32'h0);
        check("rst_strobe", 32'(sample_strobe), 32'h0);
        check("rst_ch_ready", 32'(ch_ready), 32'h0);
        check("rst_underrun", 32'(underrun), 32'h0);
        model_reset();
        repeat (2) @(negedge clk);

        reset  = 1'b0;
        active = 1'b1;
        for (int n = 0; n < 30 * DIV; n++) begin
            if (n > 0) @(negedge clk);
            cyc = n;
            drive(1, n / DIV, n % DIV);
            model_step();
        end
        #3;
        active = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
